// File: rtl/float_adder_arbiter.sv
// Round-robin front end that time-shares one FloatAdder among NUM_REQ clients.
// One op in flight: grant, pulse InputValid, wait for ResultValid (or time out), respond.
module float_adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int MIN_LAT = 2,
    parameter int MAX_LAT = 64
) (
    input  logic                     Clock,
    input  logic                     ResetN,
    input  logic [NUM_REQ-1:0]       ReqValid,
    output logic [NUM_REQ-1:0]       ReqReady,
    input  logic [NUM_REQ-1:0][31:0] ReqOp1,
    input  logic [NUM_REQ-1:0][31:0] ReqOp2,
    output logic                     RspValid,
    input  logic                     RspReady,
    output logic [31:0]              RspResult,
    output logic [ID_W-1:0]          RspId,
    output logic                     RspErr,
    output logic [31:0]              AddOp1,
    output logic [31:0]              AddOp2,
    output logic                     AddInValid,
    input  logic [31:0]              AddResult,
    input  logic                     AddResultValid,
    output logic                     Busy
);
    localparam int          CNT_W = $clog2(MAX_LAT + 1);
    localparam logic [31:0] QNAN  = 32'h7FC0_0000;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e           state_q;
    logic [ID_W-1:0]  ptr_q, id_q, gnt_idx, scan_idx;
    logic             gnt_vld;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      op1_q, op2_q, rsp_result_q;
    logic [ID_W-1:0]  rsp_id_q;
    logic             rsp_valid_q, rsp_err_q, add_in_valid_q, busy_q;

    // Scan from the farthest offset down so the nearest requester after ptr wins.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (ReqValid[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    always_comb begin
        ReqReady = '0;
        if (ResetN && state_q == S_IDLE && gnt_vld)
            ReqReady[gnt_idx] = 1'b1;
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q        <= S_IDLE;
            ptr_q          <= '0;
            id_q           <= '0;
            cnt_q          <= '0;
            op1_q          <= '0;
            op2_q          <= '0;
            rsp_result_q   <= '0;
            rsp_id_q       <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_err_q      <= 1'b0;
            add_in_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            add_in_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (gnt_vld) begin
                        op1_q          <= ReqOp1[gnt_idx];
                        op2_q          <= ReqOp2[gnt_idx];
                        id_q           <= gnt_idx;
                        ptr_q          <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                        add_in_valid_q <= 1'b1;
                        busy_q         <= 1'b1;
                        state_q        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // ResultValid is a level that is still high from the previous op
                    // until the adder wakes up, so the first MIN_LAT cycles are blind.
                    if (cnt_q >= CNT_W'(MIN_LAT) && AddResultValid) begin
                        rsp_result_q <= AddResult;
                        rsp_err_q    <= 1'b0;
                        rsp_id_q     <= id_q;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
                    end else if (cnt_q == CNT_W'(MAX_LAT - 1)) begin
                        rsp_result_q <= QNAN;
                        rsp_err_q    <= 1'b1;
                        rsp_id_q     <= id_q;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    if (RspReady) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign AddOp1     = op1_q;
    assign AddOp2     = op2_q;
    assign AddInValid = add_in_valid_q;
    assign RspValid   = rsp_valid_q;
    assign RspResult  = rsp_result_q;
    assign RspId      = rsp_id_q;
    assign RspErr     = rsp_err_q;
    assign Busy       = busy_q;

endmodule
